cache_scan_loader: RTL and testbench

//  Command-driven initiator for the cache SRAM scan port. It drives scan_enb/scan_addr/scan_data/scan_web_*
//  so that the tag, data and meta SRAMs can be invalidated, filled with a constant, or preloaded from a
//  32-bit word stream (debug host or boot ROM). Before touching the SRAMs it obtains quiescence from the

---
 rtl/cache_scan_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_cache_scan_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_scan_loader.sv
// cache_scan_loader: scan-port initiator that invalidates, fills or preloads the
// cache tag/data/meta SRAMs once the cache controller has gone quiet.
module cache_scan_loader #(
    parameter int NUM_WAYS = 4,
    parameter int CACHE_AW = 9,
    parameter int TAG_AW   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_vld_i,
    output logic                cmd_rdy_o,
    input  logic [31:0]         cmd_dat_i,
    output logic                quiesce_req_o,
    input  logic                quiesce_ack_i,
    output logic                scan_enb_o,
    output logic [CACHE_AW-1:0] scan_addr_o,
    output logic [31:0]         scan_data_o,
    output logic [NUM_WAYS-1:0] scan_web_tag_o,
    output logic [NUM_WAYS-1:0] scan_web_cache_o,
    output logic                scan_web_meta_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_FILL  = 2'b01,
        OP_INVAL = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        TGT_TAG   = 2'b00,
        TGT_CACHE = 2'b01,
        TGT_META  = 2'b10,
        TGT_RSVD  = 2'b11
    } tgt_e;

    typedef enum logic [3:0] {
        IDLE, QREQ, OWN, WDATA, FCONST, FILL, INV, DRAIN, REL
    } state_e;

    localparam logic [CACHE_AW-1:0] INV_LAST = CACHE_AW'((1 << TAG_AW) - 1);

    state_e              state_q;
    op_e                 op_q;
    tgt_e                tgt_q;
    logic [NUM_WAYS-1:0] mask_q;
    logic [CACHE_AW-1:0] addr_q;
    logic [CACHE_AW-1:0] cnt_q;

    logic                rdy_q;
    logic                req_q;
    logic                enb_q;
    logic [CACHE_AW-1:0] saddr_q;
    logic [31:0]         sdata_q;
    logic [NUM_WAYS-1:0] wtag_q;
    logic [NUM_WAYS-1:0] wcache_q;
    logic                wmeta_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    op_e                 hdr_op;
    tgt_e                hdr_tgt;
    logic [NUM_WAYS-1:0] hdr_mask;
    logic [CACHE_AW-1:0] hdr_addr;
    logic [CACHE_AW-1:0] hdr_cnt;
    logic                hdr_bad;
    logic                hdr_unused;

    logic                hs;
    logic                wrap_tag;
    logic                wr_go;
    logic [31:0]         wr_data;
    logic [CACHE_AW-1:0] addr_d;
    logic [NUM_WAYS-1:0] wtag_d;
    logic [NUM_WAYS-1:0] wcache_d;
    logic                wmeta_d;

    assign hdr_op     = op_e'(cmd_dat_i[31:30]);
    assign hdr_mask   = cmd_dat_i[26 +: NUM_WAYS];
    assign hdr_tgt    = tgt_e'(cmd_dat_i[25:24]);
    assign hdr_addr   = cmd_dat_i[15 +: CACHE_AW];
    assign hdr_cnt    = cmd_dat_i[6 +: CACHE_AW];
    assign hdr_unused = ^cmd_dat_i[5:0];

    // The way mask only matters for the tag and data arrays.
    assign hdr_bad = (hdr_op == OP_RSVD) || (hdr_tgt == TGT_RSVD) ||
                     ((hdr_mask == '0) &&
                      ((hdr_tgt == TGT_TAG) || (hdr_tgt == TGT_CACHE)));

    assign hs       = cmd_vld_i && rdy_q;
    assign wrap_tag = (op_q == OP_INVAL) || (tgt_q != TGT_CACHE);

    always_comb begin
        addr_d = addr_q + 1'b1;
        if (wrap_tag) begin
            addr_d[CACHE_AW-1:TAG_AW] = '0;
        end
    end

    always_comb begin
        wtag_d   = '1;
        wcache_d = '1;
        wmeta_d  = 1'b1;
        if (op_q == OP_INVAL) begin
            wtag_d  = '0;
            wmeta_d = 1'b0;
        end else begin
            unique case (tgt_q)
                TGT_TAG:   wtag_d   = ~mask_q;
                TGT_CACHE: wcache_d = ~mask_q;
                default:   wmeta_d  = 1'b0;
            endcase
        end
    end

    always_comb begin
        wr_go   = 1'b0;
        wr_data = sdata_q;
        unique case (state_q)
            WDATA: begin
                wr_go   = hs;
                wr_data = cmd_dat_i;
            end
            FILL:  wr_go = 1'b1;
            INV: begin
                wr_go   = 1'b1;
                wr_data = '0;
            end
            default: wr_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= OP_WRITE;
            tgt_q    <= TGT_TAG;
            mask_q   <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            req_q    <= 1'b0;
            enb_q    <= 1'b1;
            saddr_q  <= '0;
            sdata_q  <= '0;
            wtag_q   <= '1;
            wcache_q <= '1;
            wmeta_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wtag_q   <= '1;
            wcache_q <= '1;
            wmeta_q  <= 1'b1;
            if (wr_go) begin
                saddr_q  <= addr_q;
                sdata_q  <= wr_data;
                wtag_q   <= wtag_d;
                wcache_q <= wcache_d;
                wmeta_q  <= wmeta_d;
                addr_q   <= addr_d;
                cnt_q    <= cnt_q - 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (hs) begin
                        op_q   <= hdr_op;
                        tgt_q  <= hdr_tgt;
                        mask_q <= hdr_mask;
                        if (hdr_op == OP_INVAL) begin
                            addr_q <= '0;
                            cnt_q  <= INV_LAST;
                        end else begin
                            addr_q <= hdr_addr;
                            if (hdr_tgt != TGT_CACHE) begin
                                addr_q[CACHE_AW-1:TAG_AW] <= '0;
                            end
                            cnt_q <= hdr_cnt;
                        end
                        if (hdr_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            rdy_q   <= 1'b0;
                            req_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= QREQ;
                        end
                    end
                end
                QREQ: begin
                    if (quiesce_ack_i) begin
                        enb_q   <= 1'b0;
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    unique case (op_q)
                        OP_WRITE: begin
                            rdy_q   <= 1'b1;
                            state_q <= WDATA;
                        end
                        OP_FILL: begin
                            rdy_q   <= 1'b1;
                            state_q <= FCONST;
                        end
                        default: state_q <= INV;
                    endcase
                end
                WDATA, FILL, INV: begin
                    if (wr_go && (cnt_q == '0)) begin
                        rdy_q   <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                FCONST: begin
                    if (hs) begin
                        sdata_q <= cmd_dat_i;
                        rdy_q   <= 1'b0;
                        state_q <= FILL;
                    end
                end
                DRAIN: state_q <= REL;
                REL: begin
                    enb_q   <= 1'b1;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_rdy_o        = rdy_q;
    assign quiesce_req_o    = req_q;
    assign scan_enb_o       = enb_q;
    assign scan_addr_o      = saddr_q;
    assign scan_data_o      = sdata_q;
    assign scan_web_tag_o   = wtag_q;
    assign scan_web_cache_o = wcache_q;
    assign scan_web_meta_o  = wmeta_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_cache_scan_loader.sv
// tb_cache_scan_loader: table of commands checked through a write scoreboard,
// plus hand-written reset and mid-command reset sequences.
`timescale 1ns/1ps
module tb_cache_scan_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_vld_i = 1'b0;
    logic [31:0] cmd_dat_i = '0;
    logic        quiesce_ack_i = 1'b0;
    logic        cmd_rdy_o;
    logic        quiesce_req_o;
    logic        scan_enb_o;
    logic [8:0]  scan_addr_o;
    logic [31:0] scan_data_o;
    logic [3:0]  scan_web_tag_o;
    logic [3:0]  scan_web_cache_o;
    logic        scan_web_meta_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    cache_scan_loader dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_vld_i        (cmd_vld_i),
        .cmd_rdy_o        (cmd_rdy_o),
        .cmd_dat_i        (cmd_dat_i),
        .quiesce_req_o    (quiesce_req_o),
        .quiesce_ack_i    (quiesce_ack_i),
        .scan_enb_o       (scan_enb_o),
        .scan_addr_o      (scan_addr_o),
        .scan_data_o      (scan_data_o),
        .scan_web_tag_o   (scan_web_tag_o),
        .scan_web_cache_o (scan_web_cache_o),
        .scan_web_meta_o  (scan_web_meta_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  wtag;
        logic [3:0]  wcache;
        logic        wmeta;
    } wr_t;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  mask;
        logic [1:0]  tgt;
        logic [8:0]  addr;
        logic [8:0]  cnt1;
        logic [31:0] dat;
        int          delay;
        bit          rej;
        string       name;
    } cmd_t;

    wr_t  sb[$];
    cmd_t tbl[10];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   err_cnt = 0;
    int   ack_delay = 0;
    int   req_cyc = 0;
    bit   req_seen = 1'b0;
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic wr_t mk(input logic [1:0] op, input logic [1:0] tgt,
                               input logic [3:0] mask, input logic [8:0] a,
                               input logic [31:0] d);
        wr_t r;
        r.addr   = a;
        r.data   = d;
        r.wtag   = 4'hF;
        r.wcache = 4'hF;
        r.wmeta  = 1'b1;
        if (op == 2'b10) begin
            r.wtag  = 4'h0;
            r.wmeta = 1'b0;
        end else if (tgt == 2'b00) begin
            r.wtag = ~mask;
        end else if (tgt == 2'b01) begin
            r.wcache = ~mask;
        end else begin
            r.wmeta = 1'b0;
        end
        return r;
    endfunction

    function automatic cmd_t ent(input logic [1:0] op, input logic [3:0] mask,
                                 input logic [1:0] tgt, input logic [8:0] addr,
                                 input logic [8:0] cnt1, input logic [31:0] dat,
                                 input int delay, input bit rej, input string name);
        cmd_t c;
        c.op = op; c.mask = mask; c.tgt = tgt; c.addr = addr; c.cnt1 = cnt1;
        c.dat = dat; c.delay = delay; c.rej = rej; c.name = name;
        return c;
    endfunction

    // controller model: ack after ack_delay cycles of req, drop with req
    initial forever begin
        @(negedge clk);
        if (quiesce_req_o) req_cyc++;
        else req_cyc = 0;
        quiesce_ack_i = quiesce_req_o && (req_cyc > ack_delay);
    end

    // write monitor and scoreboard
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (mon_on) begin
            if (quiesce_req_o) req_seen = 1'b1;
            if (err_o) err_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if ((scan_web_tag_o != 4'hF) || (scan_web_cache_o != 4'hF) ||
                !scan_web_meta_o) begin
                wr_t got;
                got = {scan_addr_o, scan_data_o, scan_web_tag_o,
                       scan_web_cache_o, scan_web_meta_o};
                wr_cnt++;
                if (wr_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'(got), 64'(0));
                end else begin
                    chk("write", 64'(got), 64'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        cmd_vld_i = 1'b1;
        cmd_dat_i = w;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_rdy_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        cmd_vld_i = 1'b0;
    endtask

    task automatic run_cmd(input cmd_t c);
        logic [31:0] hdr;
        logic [8:0]  a;
        logic [31:0] d;
        int          n;
        int          hi;
        bit          ok;
        bit          all_ok;
        hdr = {c.op, c.mask, c.tgt, c.addr, c.cnt1, 6'b101010};
        n = (c.op == 2'b10) ? 256 : int'(c.cnt1) + 1;
        ack_delay = c.delay;
        wr_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
        req_seen = 1'b0;
        if (!c.rej) begin
            for (int i = 0; i < n; i++) begin
                if (c.op == 2'b10) a = 9'(i);
                else if (c.tgt == 2'b01) a = 9'((int'(c.addr) + i) % 512);
                else a = 9'((int'(c.addr) % 256 + i) % 256);
                if (c.op == 2'b00) d = c.dat + 32'(i);
                else if (c.op == 2'b01) d = c.dat;
                else d = 32'h0;
                sb.push_back(mk(c.op, c.tgt, c.mask, a, d));
            end
        end
        send(hdr, ok);
        chk({c.name, "_hdr_taken"}, 64'(ok), 64'(1));
        if (c.rej) begin
            chk({c.name, "_err_pulse"}, 64'(err_o), 64'(1));
            repeat (4) @(negedge clk);
            chk({c.name, "_err_count"}, 64'(err_cnt), 64'(1));
            chk({c.name, "_no_quiesce"}, 64'(req_seen), 64'(0));
            chk({c.name, "_no_write"}, 64'(wr_cnt), 64'(0));
        end else begin
            chk({c.name, "_busy"}, 64'(busy_o), 64'(1));
            hi = 0;
            for (int k = 0; k < 100; k++) begin
                if (!scan_enb_o) break;
                hi++;
                @(negedge clk);
            end
            chk({c.name, "_enb_until_ack"}, 64'(hi), 64'(c.delay + 1));
            all_ok = 1'b1;
            if (c.op == 2'b00) begin
                for (int i = 0; i < n; i++) begin
                    send(c.dat + 32'(i), ok);
                    all_ok &= ok;
                end
            end else if (c.op == 2'b01) begin
                send(c.dat, ok);
                all_ok &= ok;
            end
            chk({c.name, "_payload_taken"}, 64'(all_ok), 64'(1));
            for (int k = 0; k < 2000; k++) begin
                if (done_cnt != 0) break;
                @(negedge clk);
            end
            chk({c.name, "_done"}, 64'(done_cnt), 64'(1));
            chk({c.name, "_wr_count"}, 64'(wr_cnt), 64'(n));
            chk({c.name, "_sb_empty"}, 64'(sb.size()), 64'(0));
            chk({c.name, "_no_gaps"}, 64'(last_cyc - first_cyc), 64'(n - 1));
            chk({c.name, "_done_lat"}, 64'(done_cyc - last_cyc), 64'(2));
            chk({c.name, "_released"},
                64'({scan_enb_o, quiesce_req_o, busy_o, cmd_rdy_o}), 64'(4'b1001));
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] hdr;
        bit          ok;
        bit          tog;
        int          idx;

        tbl[0] = ent(2'b00, 4'b0101, 2'b01, 9'd510,  9'd2,   32'hA000_000A, 0,  1'b0, "wr_cache_wrap");
        tbl[1] = ent(2'b01, 4'b0000, 2'b10, 9'h1FE,  9'd3,   32'hDEAD_BEEF, 2,  1'b0, "fill_meta");
        tbl[2] = ent(2'b10, 4'b1111, 2'b00, 9'd0,    9'd0,   32'h0,         10, 1'b0, "inval");
        tbl[3] = ent(2'b11, 4'b1111, 2'b01, 9'd0,    9'd3,   32'h0,         0,  1'b1, "rej_op");
        tbl[4] = ent(2'b00, 4'b1111, 2'b11, 9'd0,    9'd3,   32'h0,         0,  1'b1, "rej_tgt");
        tbl[5] = ent(2'b00, 4'b0000, 2'b00, 9'd0,    9'd3,   32'h0,         0,  1'b1, "rej_mask_tag");
        tbl[6] = ent(2'b01, 4'b0000, 2'b01, 9'd0,    9'd3,   32'h0,         0,  1'b1, "rej_mask_cache");
        tbl[7] = ent(2'b00, 4'b1000, 2'b00, 9'h1FF,  9'd1,   32'h7700_0000, 1,  1'b0, "wr_tag_wrap");
        tbl[8] = ent(2'b01, 4'b0011, 2'b01, 9'd5,    9'd511, 32'h1234_5678, 0,  1'b0, "fill_cache_max");
        tbl[9] = ent(2'b00, 4'b0000, 2'b10, 9'h013,  9'd0,   32'h5555_AAAA, 3,  1'b0, "wr_meta_one");

        // reset held with a valid word on the command port
        reset = 1'b0;
        cmd_vld_i = 1'b1;
        cmd_dat_i = 32'h4700_0000;
        repeat (3) @(negedge clk);
        chk("rst_enb", 64'(scan_enb_o), 64'(1));
        chk("rst_webs", 64'({scan_web_tag_o, scan_web_cache_o, scan_web_meta_o}),
            64'(9'h1FF));
        chk("rst_rdy_req", 64'({cmd_rdy_o, quiesce_req_o}), 64'(0));
        chk("rst_flags", 64'({busy_o, done_o, err_o}), 64'(0));
        chk("rst_addr_data", 64'({scan_addr_o, scan_data_o}), 64'(0));
        cmd_vld_i = 1'b0;
        reset = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 10; t++) begin
            run_cmd(tbl[t]);
        end

        // WRITE with a gappy word stream, reset after the fifth write
        ack_delay = 0;
        wr_cnt = 0;
        sb.delete();
        hdr = {2'b00, 4'b1111, 2'b01, 9'd100, 9'd7, 6'd0};
        send(hdr, ok);
        chk("gap_hdr_taken", 64'(ok), 64'(1));
        tog = 1'b1;
        idx = 0;
        for (int k = 0; k < 200; k++) begin
            if (wr_cnt >= 5) break;
            cmd_vld_i = tog;
            cmd_dat_i = 32'h6000_0000 + 32'(idx);
            if (tog && cmd_rdy_o) begin
                sb.push_back(mk(2'b00, 2'b01, 4'b1111, 9'(100 + idx),
                                32'h6000_0000 + 32'(idx)));
                idx++;
            end
            tog = !tog;
            @(negedge clk);
        end
        reset = 1'b0;
        cmd_vld_i = 1'b0;
        @(negedge clk);
        chk("midrst_enb", 64'(scan_enb_o), 64'(1));
        chk("midrst_webs", 64'({scan_web_tag_o, scan_web_cache_o, scan_web_meta_o}),
            64'(9'h1FF));
        chk("midrst_req_busy", 64'({quiesce_req_o, busy_o}), 64'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_accepted", 64'(idx), 64'(5));
        chk("midrst_written", 64'(wr_cnt), 64'(idx));
        chk("midrst_sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
